// File: rtl/chan_scan_mux_pkg.sv
// Shared definitions for the channel scan multiplexer: mode encoding and
// default geometry used by the top level and the data-select sub-module.
package chan_scan_mux_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NCH   = 16;

endpackage : chan_scan_mux_pkg

// File: rtl/chan_scan_mux_mux_n1.sv
// Purely combinational WIDTH-bit NCH:1 data selector over a flat channel bus
// where channel k occupies bits [k*WIDTH +: WIDTH].
module mux_n1
    import chan_scan_mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NCH   = DEF_NCH,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic [NCH*WIDTH-1:0] i_data,
    input  logic [SELW-1:0]      i_sel,
    output logic [WIDTH-1:0]     o_data
);

    logic [WIDTH-1:0] w_lane [NCH];

    for (genvar k = 0; k < NCH; k++) begin : g_lane
        assign w_lane[k] = i_data[k*WIDTH +: WIDTH];
    end

    assign o_data = w_lane[i_sel];

endmodule : mux_n1

// File: rtl/chan_scan_mux.sv
// Channel multiplexer with manual select or round-robin scan over enabled
// channels, feeding a single-entry registered output stage with backpressure.
module chan_scan_mux
    import chan_scan_mux_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int NCH   = DEF_NCH,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [NCH-1:0]       ch_en,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SELW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic             r_out_valid;

    logic             w_scan;
    logic [SELW-1:0]  w_cur;
    logic             w_can_load;
    logic             w_gate;
    logic             w_capture;
    logic [NCH-1:0]   w_in_ready;
    logic [SELW-1:0]  w_ptr_nxt;
    logic [WIDTH-1:0] w_sel_data;

    mux_n1 #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) u_mux (
        .i_data (in_data),
        .i_sel  (w_cur),
        .o_data (w_sel_data)
    );

    // Channel selection, capture decision, capture strobe and scan pointer step.
    always_comb begin
        w_scan     = (mode_e'(mode) == MODE_SCAN);
        w_cur      = sel;
        w_gate     = 1'b1;
        w_in_ready = '0;
        w_ptr_nxt  = r_ptr;

        if (w_scan) begin
            w_cur  = r_ptr;
            w_gate = ch_en[r_ptr];
        end else begin
            w_cur  = sel;
            w_gate = 1'b1;
        end

        w_can_load = ~r_out_valid | out_ready;
        // rst_n gates the strobe so nothing is offered as accepted during reset.
        w_capture  = rst_n & w_can_load & in_valid[w_cur] & w_gate;

        if (w_capture) begin
            w_in_ready[w_cur] = 1'b1;
        end else begin
            w_in_ready = '0;
        end

        // A disabled channel is always skipped; an enabled one waits for room.
        if (w_scan && (!ch_en[r_ptr] || w_can_load)) begin
            w_ptr_nxt = r_ptr + SELW'(1);
        end else begin
            w_ptr_nxt = r_ptr;
        end
    end

    // Scan pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Single-entry output stage: load on capture, drain on out_ready, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_ch    <= w_cur;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

endmodule : chan_scan_mux

// File: tb/tb_chan_scan_mux.sv
// Self-checking bench for chan_scan_mux: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_chan_scan_mux;
    import chan_scan_mux_pkg::*;

    localparam int WIDTH = 8;
    localparam int NCH   = 16;
    localparam int SELW  = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NCH*WIDTH-1:0] in_data = '0;
    logic [NCH-1:0]       in_valid = '0;
    logic [NCH-1:0]       in_ready;
    logic [NCH-1:0]       ch_en = '0;
    logic                 mode = 1'b0;
    logic [SELW-1:0]      sel = '0;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_ch;
    logic                 out_valid;
    logic                 out_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: held output item and scan position.
    int               m_ptr = 0;
    bit               m_valid = 1'b0;
    logic [WIDTH-1:0] m_data = '0;
    int               m_ch = 0;
    bit               m_take;
    int               m_cur;
    logic [NCH-1:0]   m_ready_exp;

    chan_scan_mux #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ch_en     (ch_en),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] chan_word(int k);
        return in_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic model_predict();
        bit room;
        room   = !m_valid || out_ready;
        m_cur  = (mode == MODE_SCAN) ? m_ptr : int'(sel);
        m_take = room && in_valid[m_cur] && ((mode == MODE_MANUAL) || ch_en[m_cur]);
        m_ready_exp = m_take ? (NCH'(1) << m_cur) : '0;
    endtask

    task automatic model_clock();
        bit room;
        room = !m_valid || out_ready;
        if (m_take) begin
            m_data  = chan_word(m_cur);
            m_ch    = m_cur;
            m_valid = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (mode == MODE_SCAN && (!ch_en[m_ptr] || room))
            m_ptr = (m_ptr + 1) % NCH;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_ch    = 0;
    endtask

    task automatic check_outputs(input string tag);
        vectors++;
        if (out_valid !== m_valid) begin
            miscompares++;
            $display("FAIL %s out_valid: got %b want %b", tag, out_valid, m_valid);
        end
        vectors++;
        if (out_data !== m_data) begin
            miscompares++;
            $display("FAIL %s out_data: got %h want %h", tag, out_data, m_data);
        end
        vectors++;
        if (out_ch !== SELW'(m_ch)) begin
            miscompares++;
            $display("FAIL %s out_ch: got %0d want %0d", tag, out_ch, m_ch);
        end
    endtask

    // One clock: check in_ready for the current inputs, clock, then check outputs.
    task automatic step(input string tag);
        #1;
        model_predict();
        vectors++;
        if (in_ready !== m_ready_exp) begin
            miscompares++;
            $display("FAIL %s in_ready: got %h want %h", tag, in_ready, m_ready_exp);
        end
        @(posedge clk);
        model_clock();
        #1;
        check_outputs(tag);
    endtask

    task automatic randomize_data();
        for (int k = 0; k < NCH; k++) in_data[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    endtask

    task automatic do_reset();
        in_valid  = '1;
        out_ready = 1'b1;
        mode      = MODE_MANUAL;
        rst_n     = 1'b0;
        model_reset();
        #1;
        check_outputs("reset_async");
        vectors++;
        if (in_ready !== '0) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %h want 0", in_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset_hold");
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        randomize_data();
        do_reset();
    endtask

    task automatic test_manual();
        do_reset();
        randomize_data();
        mode      = MODE_MANUAL;
        sel       = 4'd5;
        in_valid  = 16'h0020;
        in_data[5*WIDTH +: WIDTH] = 8'hA5;
        out_ready = 1'b1;
        repeat (4) begin
            step("manual");
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 4'd5) begin
                miscompares++;
                $display("FAIL manual_sel5: got v=%b d=%h ch=%0d want v=1 d=a5 ch=5",
                         out_valid, out_data, out_ch);
            end
        end
    endtask

    task automatic test_scan_mask();
        int seen[$];
        int exp_seq[4] = '{0, 4, 0, 4};
        do_reset();
        randomize_data();
        mode      = MODE_SCAN;
        ch_en     = 16'h0011;
        in_valid  = '1;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && seen.size() < 4; c++) begin
            step("scan_mask");
            if (out_valid === 1'b1) seen.push_back(int'(out_ch));
        end
        vectors++;
        if (seen.size() != 4) begin
            miscompares++;
            $display("FAIL scan_mask_count: got %0d items want 4", seen.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (seen[i] != exp_seq[i]) begin
                    miscompares++;
                    $display("FAIL scan_mask_seq[%0d]: got %0d want %0d", i, seen[i], exp_seq[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        randomize_data();
        mode      = MODE_MANUAL;
        sel       = 4'd2;
        in_valid  = 16'h0004;
        out_ready = 1'b1;
        in_data[2*WIDTH +: WIDTH] = 8'h11;
        step("bp_first");
        out_ready = 1'b0;
        in_data[2*WIDTH +: WIDTH] = 8'h22;
        repeat (3) begin
            step("bp_stall");
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 8'h11 || out_ch !== 4'd2 || in_ready !== '0) begin
                miscompares++;
                $display("FAIL bp_hold: got v=%b d=%h ch=%0d rdy=%h want v=1 d=11 ch=2 rdy=0",
                         out_valid, out_data, out_ch, in_ready);
            end
        end
        out_ready = 1'b1;
        step("bp_release");
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h22) begin
            miscompares++;
            $display("FAIL bp_no_bubble: got v=%b d=%h want v=1 d=22", out_valid, out_data);
        end
        in_data[2*WIDTH +: WIDTH] = 8'h33;
        step("bp_stream");
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 8'h33) begin
            miscompares++;
            $display("FAIL bp_stream: got v=%b d=%h want v=1 d=33", out_valid, out_data);
        end
    endtask

    task automatic test_wrap();
        int got[$];
        do_reset();
        randomize_data();
        mode      = MODE_SCAN;
        ch_en     = 16'h8001;
        in_valid  = 16'h8000;
        out_ready = 1'b1;
        for (int c = 0; c < 40 && got.size() < 2; c++) begin
            step("wrap");
            if (out_valid === 1'b1) begin
                got.push_back(int'(out_ch));
                in_valid = 16'h0001;
            end
        end
        vectors++;
        if (got.size() != 2 || got[0] != 15 || got[1] != 0) begin
            miscompares++;
            $display("FAIL wrap_seq: got %0d items first=%0d second=%0d want 15 then 0",
                     got.size(), (got.size() > 0) ? got[0] : -1, (got.size() > 1) ? got[1] : -1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        randomize_data();
        mode      = MODE_MANUAL;
        sel       = 4'd9;
        in_valid  = 16'h0200;
        out_ready = 1'b0;
        step("rstmid_load");
        step("rstmid_stall");
        do_reset();
        randomize_data();
        mode      = MODE_SCAN;
        ch_en     = '1;
        in_valid  = '1;
        out_ready = 1'b1;
        step("rstmid_scan");
        vectors++;
        if (out_valid !== 1'b1 || out_ch !== 4'd0) begin
            miscompares++;
            $display("FAIL rstmid_ptr0: got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch);
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        randomize_data();
        mode      = MODE_SCAN;
        ch_en     = '1;
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (7) step("ms_advance");
        mode     = MODE_MANUAL;
        sel      = 4'd3;
        in_valid = 16'h0008;
        repeat (3) step("ms_manual");
        vectors++;
        if (out_ch !== 4'd3) begin
            miscompares++;
            $display("FAIL ms_manual_ch: got %0d want 3", out_ch);
        end
        mode     = MODE_SCAN;
        in_valid = '1;
        step("ms_resume");
        vectors++;
        if (out_valid !== 1'b1 || out_ch !== 4'd7 || out_data !== in_data[7*WIDTH +: WIDTH]) begin
            miscompares++;
            $display("FAIL ms_resume: got v=%b ch=%0d d=%h want v=1 ch=7 d=%h",
                     out_valid, out_ch, out_data, in_data[7*WIDTH +: WIDTH]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            randomize_data();
            in_valid  = NCH'($urandom);
            ch_en     = ($urandom_range(0, 7) == 0) ? '0 : NCH'($urandom);
            if ($urandom_range(0, 9) == 0) mode = ~mode;
            sel       = SELW'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            step("random");
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_scan_mask();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_mode_switch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_chan_scan_mux

// File: doc/chan_scan_mux.md
CHAN_SCAN_MUX -- requirements
Module: chan_scan_mux

Interface
REQ-001 Parameter WIDTH, default 8: data bits per channel, 1..64.
REQ-002 Parameter NCH, default 16: channel count, power of two, 2..64.
REQ-003 Derived constant SELW = clog2(NCH): channel-index width, not overridable.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 Port in_data, input, NCH*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, NCH: per-channel data-valid.
REQ-008 Port in_ready, output, NCH: one-hot capture strobe to the channel accepted this cycle.
REQ-009 Port ch_en, input, NCH: per-channel enable mask, used in scan mode only.
REQ-010 Port mode, input, 1: 0 = MANUAL, 1 = SCAN.
REQ-011 Port sel, input, SELW: channel index used in MANUAL.
REQ-012 Port out_data, output, WIDTH: registered selected data.
REQ-013 Port out_ch, output, SELW: index of the channel that produced out_data.
REQ-014 Port out_valid, output, 1: output register holds data.
REQ-015 Port out_ready, input, 1: downstream accepts data.

Function
REQ-016 cur: the current channel index; it SHALL be sel in MANUAL and the scan pointer ptr in SCAN.
REQ-017 can_load SHALL be (!out_valid | out_ready).
REQ-018 Capture SHALL occur when can_load & in_valid[cur], and additionally ch_en[cur] in SCAN.
REQ-019 On capture, in_ready[cur] SHALL be 1 combinationally in that cycle; all other in_ready bits SHALL be 0; no capture means in_ready = 0.
REQ-020 On capture, out_data <= in_data[cur], out_ch <= cur, out_valid <= 1 at the next edge; latency is 1 cycle.
REQ-021 If out_valid & out_ready with no capture, out_valid SHALL clear at the next edge.
REQ-022 Simultaneous drain and capture SHALL sustain 1 transfer/cycle with no bubble.
REQ-023 While out_valid & !out_ready, out_data and out_ch SHALL hold stable.
REQ-024 SCAN pointer: after a capture, ptr <= ptr+1, wrapping NCH-1 -> 0.
REQ-025 SCAN pointer: when ch_en[ptr]=0, or when in_valid[ptr]=0 with can_load=1, ptr SHALL advance by 1 with wrap.
REQ-026 SCAN pointer: when can_load=0, ptr SHALL hold.
REQ-027 ch_en all zero SHALL keep ptr advancing with no capture.
REQ-028 In MANUAL, ptr SHALL hold its value.
REQ-029 A mode change SHALL take effect in the same cycle; SCAN resumes from the held ptr.
REQ-030 Changing mode or sel while out_valid=1 SHALL NOT alter the held output.

Reset
REQ-031 rst_n low SHALL asynchronously force out_valid=0, out_data=0, out_ch=0, and ptr=0.
REQ-032 in_ready SHALL be 0 while rst_n is low.
REQ-033 Reset asserted mid-transfer SHALL discard held data; no transfer is reported.
REQ-034 Deassertion SHALL be synchronised externally; the first capture may occur on the first edge after release.

Structure
REQ-035 Package chan_scan_mux_pkg SHALL hold the mode encoding (MODE_MANUAL=0, MODE_SCAN=1) and the default WIDTH/NCH constants.
REQ-036 A combinational sub-module mux_n1 (parameters WIDTH, NCH) SHALL implement the WIDTH-bit NCH:1 data select and SHALL be instantiated once.
REQ-037 The scan pointer and output register SHALL reside in chan_scan_mux; no latches.

Verification
REQ-038 MANUAL, sel=5, in_valid[5]=1, in_data[5]=0xA5, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_ch=5; in_ready[5] pulses each cycle.
REQ-039 SCAN, ch_en=0x0011, all valid, out_ready=1 -> out_ch sequence 0,4,0,4; ptr steps through masked channels without capture.
REQ-040 Backpressure: out_ready=0 for 3 cycles after capture -> out_data/out_ch stable, in_ready=0; on release, the next data follows without a bubble.
REQ-041 SCAN wrap: NCH=16, ch_en=0x8001, valid only ch15 then ch0 -> out_ch 15 then 0.
REQ-042 rst_n low while out_valid=1 -> out_valid=0 immediately, without waiting for a clock edge; ptr=0 after release.
REQ-043 Mode switch SCAN->MANUAL->SCAN with ptr=7 -> SCAN resumes at channel 7.
